// File: rtl/window_pkg.sv
// Shared constants and helpers for the 3x3 window generator and its line buffers.
package window_pkg;

   localparam int DATA_WIDTH  = 16;
   localparam int IMG_WIDTH   = 640;
   localparam int IMG_DEPTH   = 512;
   localparam int KERNEL_SIZE = 3;
   localparam int FIFO_SUM    = KERNEL_SIZE - 1;
   localparam int COL_W       = $clog2(IMG_WIDTH);
   localparam int ROW_W       = $clog2(IMG_DEPTH);
   localparam int OUT_WIDTH   = IMG_WIDTH - 2;
   localparam int OUT_DEPTH   = IMG_DEPTH - 2;

   // Address width for a RAM of the given depth, never narrower than one bit.
   function automatic int addr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// Row delay line: dout presents, at each enable, the pixel accepted DEPTH_PIX
// enables earlier. A (DEPTH_PIX-1)-deep circular RAM plus its registered read
// port together make up the full DEPTH_PIX delay.
module line_buffer #(
   parameter int DEPTH_PIX  = window_pkg::IMG_WIDTH,
   parameter int DATA_WIDTH = window_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);
   import window_pkg::*;

   localparam int RAM_DEPTH = DEPTH_PIX - 1;
   localparam int AW        = addr_bits(RAM_DEPTH);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [AW-1:0]         ptr_reg;

   // Circular pointer; advances only on accepted pixels so row alignment survives input gaps.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg <= '0;
      end else if (en) begin
         ptr_reg <= (ptr_reg == AW'(RAM_DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
      end
   end

   // Read-before-write RAM port; contents are never cleared (downstream gating hides them).
   always_ff @(posedge clk) begin
      if (en) begin
         dout         <= mem[ptr_reg];
         mem[ptr_reg] <= din;
      end
   end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: raster pixels in, interior 3x3 windows out
// with a one-cycle strobe and the window-centre coordinates.
module window_3x3_gen #(
   parameter int WIDTH       = window_pkg::IMG_WIDTH,
   parameter int DEPTH       = window_pkg::IMG_DEPTH,
   parameter int DATA_WIDTH  = window_pkg::DATA_WIDTH,
   parameter int KERNEL_SIZE = window_pkg::KERNEL_SIZE,
   parameter int FIFO_SUM    = KERNEL_SIZE - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_sof,
   input  logic                       in_valid,
   input  logic [DATA_WIDTH-1:0]      in_data,
   output logic [DATA_WIDTH-1:0]      matrix_p11,
   output logic [DATA_WIDTH-1:0]      matrix_p12,
   output logic [DATA_WIDTH-1:0]      matrix_p13,
   output logic [DATA_WIDTH-1:0]      matrix_p21,
   output logic [DATA_WIDTH-1:0]      matrix_p22,
   output logic [DATA_WIDTH-1:0]      matrix_p23,
   output logic [DATA_WIDTH-1:0]      matrix_p31,
   output logic [DATA_WIDTH-1:0]      matrix_p32,
   output logic [DATA_WIDTH-1:0]      matrix_p33,
   output logic                       matrix_clken,
   output logic [$clog2(DEPTH)-1:0]   win_row,
   output logic [$clog2(WIDTH)-1:0]   win_col,
   output logic                       frame_active,
   output logic                       frame_done
);
   import window_pkg::*;

   localparam int CB = $clog2(WIDTH);
   localparam int RB = $clog2(DEPTH);

   // The window shift below is written for exactly three taps.
   generate
      if (KERNEL_SIZE != 3 || FIFO_SUM != KERNEL_SIZE - 1) begin : g_kernel_check
         $error("window_3x3_gen supports only KERNEL_SIZE=3 with FIFO_SUM=2");
      end
      if (WIDTH < 3 || DEPTH < 3) begin : g_size_check
         $error("window_3x3_gen needs WIDTH>=3 and DEPTH>=3");
      end
   endgenerate

   logic [CB-1:0]         col_reg;
   logic [RB-1:0]         row_reg;
   logic                  done_pending_reg;
   logic                  accept;
   logic                  last_pix;
   logic                  interior;
   logic [CB-1:0]         pos_col;
   logic [RB-1:0]         pos_row;
   logic [DATA_WIDTH-1:0] line_out [FIFO_SUM+1];
   logic [DATA_WIDTH-1:0] col_in   [3];
   logic [DATA_WIDTH-1:0] win_reg  [3][3];

   // A sof pixel is always placed at (0,0), whatever the counters held.
   assign accept   = in_valid & (frame_active | in_sof);
   assign pos_col  = in_sof ? '0 : col_reg;
   assign pos_row  = in_sof ? '0 : row_reg;
   assign last_pix = (pos_row == RB'(DEPTH - 1)) && (pos_col == CB'(WIDTH - 1));
   assign interior = (pos_row >= RB'(2)) && (pos_col >= CB'(2));

   // Chain of row delays: line_out[1] is one row back, line_out[2] two rows back.
   assign line_out[0] = in_data;
   generate
      for (genvar gi = 0; gi < FIFO_SUM; gi++) begin : g_line
         line_buffer #(
            .DEPTH_PIX  (WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
         ) u_line (
            .clk  (clk),
            .rst  (rst),
            .en   (accept),
            .din  (line_out[gi]),
            .dout (line_out[gi+1])
         );
      end
   endgenerate

   // New right-hand column of the window, oldest row at the top.
   assign col_in[0] = line_out[2];
   assign col_in[1] = line_out[1];
   assign col_in[2] = in_data;

   // Raster position, frame activity and the delayed end-of-frame pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_reg          <= '0;
         row_reg          <= '0;
         frame_active     <= 1'b0;
         done_pending_reg <= 1'b0;
         frame_done       <= 1'b0;
      end else begin
         frame_done       <= done_pending_reg;
         done_pending_reg <= accept & last_pix;
         if (accept) begin
            if (last_pix) begin
               col_reg      <= '0;
               row_reg      <= '0;
               frame_active <= 1'b0;
            end else begin
               frame_active <= 1'b1;
               if (pos_col == CB'(WIDTH - 1)) begin
                  col_reg <= '0;
                  row_reg <= pos_row + 1'b1;
               end else begin
                  col_reg <= pos_col + 1'b1;
                  row_reg <= pos_row;
               end
            end
         end
      end
   end

   // Window shift register, strobe and centre coordinates; everything holds while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_reg[r][c] <= '0;
            end
         end
         matrix_clken <= 1'b0;
         win_row      <= '0;
         win_col      <= '0;
      end else begin
         matrix_clken <= accept & interior;
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               win_reg[r][0] <= win_reg[r][1];
               win_reg[r][1] <= win_reg[r][2];
               win_reg[r][2] <= col_in[r];
            end
            if (interior) begin
               win_row <= pos_row - 1'b1;
               win_col <= pos_col - 1'b1;
            end
         end
      end
   end

   assign matrix_p11 = win_reg[0][0];
   assign matrix_p12 = win_reg[0][1];
   assign matrix_p13 = win_reg[0][2];
   assign matrix_p21 = win_reg[1][0];
   assign matrix_p22 = win_reg[1][1];
   assign matrix_p23 = win_reg[1][2];
   assign matrix_p31 = win_reg[2][0];
   assign matrix_p32 = win_reg[2][1];
   assign matrix_p33 = win_reg[2][2];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on a 5x4 frame: a frame-image model predicts
// every window and frame_done; a negedge monitor pops and compares them.
module tb_window_3x3_gen;

   localparam int W  = 5;
   localparam int D  = 4;
   localparam int DW = 16;
   localparam int NWIN = (W - 2) * (D - 2);
   localparam int K_WIN  = 0;
   localparam int K_DONE = 1;

   typedef struct {
      int                   kind;
      int                   cyc;
      int                   row;
      int                   col;
      logic [8:0][DW-1:0]   p;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    in_sof = 1'b0;
   logic                    in_valid = 1'b0;
   logic [DW-1:0]           in_data = '0;
   logic [DW-1:0]           p11, p12, p13, p21, p22, p23, p31, p32, p33;
   logic                    matrix_clken;
   logic [$clog2(D)-1:0]    win_row;
   logic [$clog2(W)-1:0]    win_col;
   logic                    frame_active;
   logic                    frame_done;
   logic [8:0][DW-1:0]      act;

   exp_t        q[$];
   logic [DW-1:0] img [D][W];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          strobe_cnt = 0;
   int          done_cnt = 0;
   bit          fa_m = 1'b0;
   int          r_m = 0;
   int          c_m = 0;

   window_3x3_gen #(.WIDTH(W), .DEPTH(D), .DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_sof       (in_sof),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .matrix_p11   (p11),
      .matrix_p12   (p12),
      .matrix_p13   (p13),
      .matrix_p21   (p21),
      .matrix_p22   (p22),
      .matrix_p23   (p23),
      .matrix_p31   (p31),
      .matrix_p32   (p32),
      .matrix_p33   (p33),
      .matrix_clken (matrix_clken),
      .win_row      (win_row),
      .win_col      (win_col),
      .frame_active (frame_active),
      .frame_done   (frame_done)
   );

   assign act = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // One input cycle; the model applies the acceptance and raster rules directly.
   task automatic px(input bit v, input bit sof, input logic [DW-1:0] d);
      exp_t e;
      @(negedge clk);
      chk("frame_active", int'(frame_active), int'(fa_m));
      in_valid = v;
      in_sof   = sof;
      in_data  = d;
      if (v && (fa_m || sof)) begin
         if (sof) begin
            r_m  = 0;
            c_m  = 0;
            fa_m = 1'b1;
         end
         img[r_m][c_m] = d;
         if (r_m >= 2 && c_m >= 2) begin
            e.kind = K_WIN;
            e.cyc  = cyc + 1;
            e.row  = r_m - 1;
            e.col  = c_m - 1;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  e.p[8 - (i * 3 + j)] = img[r_m - 2 + i][c_m - 2 + j];
            q.push_back(e);
         end
         c_m++;
         if (c_m == W) begin
            c_m = 0;
            r_m++;
            if (r_m == D) begin
               r_m  = 0;
               fa_m = 1'b0;
               e.kind = K_DONE;
               e.cyc  = cyc + 2;
               e.row  = 0;
               e.col  = 0;
               e.p    = '0;
               q.push_back(e);
            end
         end
      end
   endtask

   // Drive the first npix pixels of a frame (sof on the first), with random idle gaps.
   task automatic drive_frame(input bit ramp, input int gap_pct, input int npix);
      for (int k = 0; k < npix; k++) begin
         if ($urandom_range(99) < gap_pct) begin
            for (int g = 0; g < $urandom_range(3, 1); g++)
               px(1'b0, 1'($urandom_range(1)), 16'($urandom));
         end
         px(1'b1, k == 0, ramp ? 16'((k / W) * 16 + (k % W)) : 16'($urandom));
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) px(1'b0, 1'b0, '0);
   endtask

   task automatic do_reset();
      idle(2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      fa_m = 1'b0;
      r_m  = 0;
      c_m  = 0;
      chk("rst_clken", int'(matrix_clken), 0);
      chk("rst_win_row", int'(win_row), 0);
      chk("rst_win_col", int'(win_col), 0);
      chk("rst_frame_active", int'(frame_active), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_window_zero", int'(act == '0), 1);
   endtask

   // Monitor: every strobe and every frame_done must match the head of the queue in cycle and content.
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL missed_event: kind %0d expected at cycle %0d, now %0d", q[0].kind, q[0].cyc, cyc);
         void'(q.pop_front());
      end
      if (matrix_clken) begin
         strobe_cnt++;
         checks++;
         if (q.size() == 0 || q[0].kind != K_WIN || q[0].cyc != cyc) begin
            errors++;
            $display("FAIL spurious_strobe: strobe at cycle %0d win %0d,%0d with no window expected", cyc, win_row, win_col);
         end else begin
            e = q.pop_front();
            if (act != e.p || int'(win_row) != e.row || int'(win_col) != e.col) begin
               errors++;
               $display("FAIL window: got r%0d c%0d p=%h expected r%0d c%0d p=%h", win_row, win_col, act, e.row, e.col, e.p);
            end
         end
      end
      if (frame_done) begin
         done_cnt++;
         checks++;
         if (q.size() == 0 || q[0].kind != K_DONE || q[0].cyc != cyc) begin
            errors++;
            $display("FAIL spurious_done: frame_done at cycle %0d not expected", cyc);
         end else begin
            void'(q.pop_front());
         end
      end
   end

   initial begin
      int s0, d0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_clken", int'(matrix_clken), 0);
      chk("rst_win_row", int'(win_row), 0);
      chk("rst_window_zero", int'(act == '0), 1);
      chk("rst_frame_done", int'(frame_done), 0);

      // 1: ramp frame, continuous valid
      s0 = strobe_cnt; d0 = done_cnt;
      drive_frame(1'b1, 0, W * D);
      idle(4);
      chk("s1_strobes", strobe_cnt - s0, NWIN);
      chk("s1_done", done_cnt - d0, 1);

      // 2: same ramp frame with random input gaps
      s0 = strobe_cnt; d0 = done_cnt;
      drive_frame(1'b1, 40, W * D);
      idle(4);
      chk("s2_strobes", strobe_cnt - s0, NWIN);
      chk("s2_done", done_cnt - d0, 1);

      // 3: random data; middle frame cut short by a sof on its last pixel slot
      s0 = strobe_cnt; d0 = done_cnt;
      drive_frame(1'b0, 30, W * D);
      drive_frame(1'b0, 30, W * D - 1);
      drive_frame(1'b0, 30, W * D);
      idle(4);
      chk("s3_strobes", strobe_cnt - s0, 3 * NWIN - 1);
      chk("s3_done", done_cnt - d0, 2);

      // 4: reset at (2,3) then a fresh frame
      drive_frame(1'b0, 20, 2 * W + 4);
      do_reset();
      s0 = strobe_cnt; d0 = done_cnt;
      drive_frame(1'b0, 20, W * D);
      idle(4);
      chk("s4_strobes", strobe_cnt - s0, NWIN);
      chk("s4_done", done_cnt - d0, 1);

      // 5: sof reasserted in row 3, the aborted frame must not signal done
      s0 = strobe_cnt; d0 = done_cnt;
      drive_frame(1'b1, 20, 3 * W + 2);
      drive_frame(1'b0, 20, W * D);
      idle(4);
      chk("s5_strobes", strobe_cnt - s0, NWIN + 3);
      chk("s5_done", done_cnt - d0, 1);

      // 6: valid pixels with no sof are dropped
      do_reset();
      s0 = strobe_cnt;
      for (int k = 0; k < 3 * W; k++) px(1'b1, 1'b0, 16'($urandom));
      idle(3);
      chk("s6_strobes", strobe_cnt - s0, 0);
      chk("s6_win_row", int'(win_row), 0);
      chk("s6_win_col", int'(win_col), 0);
      s0 = strobe_cnt; d0 = done_cnt;
      drive_frame(1'b0, 0, W * D);
      idle(4);
      chk("s6_after_strobes", strobe_cnt - s0, NWIN);
      chk("s6_after_done", done_cnt - d0, 1);

      chk("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator; sits directly upstream of the Gaussian filter stage.
- Accepts one raster-order pixel per valid cycle and keeps the two previous image rows in line buffers.
- Presents a full 3x3 window (matrix_p11..matrix_p33) with a qualifier strobe, and only for interior windows.
- A WIDTH x DEPTH frame yields (WIDTH-2) x (DEPTH-2) windows; 638 x 510 at the defaults.

Parameters:
- WIDTH, 640, pixels per row (columns); must be >= 3.
- DEPTH, 512, rows per frame; must be >= 3.
- DATA_WIDTH, 16, bits per pixel.
- KERNEL_SIZE, 3, window size; fixed at 3, and elaboration fails for any other value.
- FIFO_SUM, 2, number of line buffers (KERNEL_SIZE-1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_sof  input  1  start of frame; qualified by in_valid and marks pixel (0,0).
- in_valid  input  1  in_data is valid this cycle; no backpressure exists.
- in_data  input  DATA_WIDTH  pixel value.
- matrix_p11..matrix_p33  output  DATA_WIDTH each  window pixels, pRC = row R, column C, with p33 the newest pixel.
- matrix_clken  output  1  window valid strobe, one cycle per interior window.
- win_row  output  $clog2(DEPTH)  row of the window centre.
- win_col  output  $clog2(WIDTH)  column of the window centre.
- frame_active  output  1  high from the accepted sof until frame_done.
- frame_done  output  1  one-cycle pulse after the last window of the frame.

Behaviour:
- Reset (synchronous, rst=1):
  - col/row counters = 0; all matrix_p* = 0; matrix_clken = 0; win_row/win_col = 0; frame_active = 0; frame_done = 0.
  - Line-buffer RAM contents are not cleared; they are don't-care because of the output gating below.
- Pixel acceptance:
  - A pixel is accepted only when in_valid=1 and (frame_active=1 or in_sof=1). Pixels before the first sof are dropped.
  - in_sof with in_valid forces the pixel to position (0,0) and sets frame_active, including mid-frame (restart). The old partial frame is abandoned with no frame_done.
- Counters:
  - col increments on each accepted pixel and wraps at WIDTH-1 to 0, at which point row increments.
  - After pixel (DEPTH-1, WIDTH-1): row and col return to 0, frame_active clears, and frame_done pulses on the next cycle.
- Line buffers: line-buffer sub-module instances chained.
  - Instance 1 delays in_data by WIDTH accepted pixels (previous row, same column).
  - Instance 2 delays instance 1's output by WIDTH (two rows back).
  - They advance only on accepted pixels; gaps in in_valid do not disturb alignment.
- Window shift, on each accepted pixel (p13/p23/p33 are the new right-hand column):
  - p11<=p12, p12<=p13, p13<=line2_out.
  - p21<=p22, p22<=p23, p23<=line1_out.
  - p31<=p32, p32<=p33, p33<=in_data.
- Strobe and position:
  - matrix_clken is registered. It is 1 in the cycle after accepting the pixel at (r,c) when r>=2 and c>=2, otherwise 0.
  - With it, win_row=r-1 and win_col=c-1.
  - Latency from the input pixel to the strobe is 1 clock.
- Non-interior windows: windows with c<2 contain previous-row wrap data and windows with r<2 contain stale RAM. The strobe is suppressed for both.
- Idle cycles (in_valid=0): matrix_p*, win_row and win_col hold their values; matrix_clken=0.
- Strobe count: exactly (WIDTH-2)*(DEPTH-2) strobes per complete frame.
- No arithmetic: pixel values pass through unmodified.
- Simultaneous events:
  - rst has priority over everything.
  - in_sof on the same cycle as the last pixel of a frame: treat it as sof of the new frame, and suppress frame_done.

Decomposition:
- Shared package window_pkg:
  - DATA_WIDTH.
  - IMG_WIDTH=640, IMG_DEPTH=512.
  - KERNEL_SIZE=3.
  - Derived COL_W/ROW_W widths.
  - OUT_WIDTH/OUT_DEPTH = IMG-2.
- Sub-module line_buffer (params DEPTH_PIX, DATA_WIDTH; ports clk, rst, en, din, dout):
  - Circular RAM with a wrapping address pointer; read-before-write, so dout is the value written WIDTH enables ago.
  - Instantiated FIFO_SUM times.

Test Plan:
1. WIDTH=5, DEPTH=4, ramp in_data=row*16+col, continuous valid -> 6 strobes; first strobe at win_row=1, win_col=1 with p11..p33 = 0x00,01,02,10,11,12,20,21,22; frame_done 1 cycle after the strobe for (2,3).
2. Same frame with in_valid toggled in a random pattern -> identical 6 windows and values as scenario 1; matrix_clken never high in an idle-input cycle.
3. Defaults 640x512 with random data -> exactly 325380 strobes; each window equals the golden-model 3x3 at its win_row/win_col.
4. rst asserted mid-frame (row 2, col 3), then a new sof frame -> all outputs 0 the cycle after rst; new frame strobes are correct, with no stale-window strobe.
5. in_sof reasserted at row 3 of a 5x4 frame -> no frame_done for the aborted frame; the restarted frame produces 6 correct windows and one frame_done.
6. Pixels with in_valid=1 but no preceding sof -> ignored: frame_active=0, no strobes, counters stay 0.
